mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
Sequential select generator that sits directly upstream of the 4-input mux and drives its a (LSB) and b select inputs. It scans the enabled mux channels round-robin and holds each channel for a programmable dwell time. It pulses a sample strobe at the end of each dwell so the consumer of the mux output y can capture a settled value. Single-sweep and continuous modes are supported.

Parameters:
DWELL_W, 8, width of the dwell-time input and of the internal dwell counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a scan; sampled only in IDLE
stop  input  1  abort the scan; return to IDLE at next edge
continuous  input  1  1 = repeat sweeps until stop; 0 = one sweep then done; latched at start
chan_mask  input  4  bit k enables select value k = {b,a}; mapping: k=0 routes x4, 1 routes x3, 2 routes x2, 3 routes x1; latched at start
dwell  input  DWELL_W  cycles each channel is held; 0 is treated as 1; latched at start
a  output  1  mux select LSB (registered)
b  output  1  mux select MSB (registered)
sample  output  1  one-cycle strobe, high in the last dwell cycle of each channel
busy  output  1  high while scanning
done  output  1  one-cycle pulse after the final sample of a single sweep

Behaviour:
- Reset: rst=1 at an edge forces state IDLE and a=0, b=0, sample=0, busy=0, done=0, dwell counter=0. Reset mid-scan aborts it: no done pulse and no sample.
- States: IDLE, DWELL. State is encoded in two bits.
- Priority at each edge: rst, then stop, then start and normal progress.
- IDLE, start=1, chan_mask!=0, stop=0:
  - latch mask, max(dwell,1) and continuous;
  - at the next edge {b,a} = lowest enabled k, busy=1, counter=1, enter DWELL.
- IDLE, start with chan_mask==0: ignored. No busy and no done.
- IDLE, start and stop together: stop wins; remain in IDLE.
- In IDLE, a and b hold their last value.
- Dwell cycles: the first cycle after {b,a} changes is dwell cycle 1. sample=1 exactly during dwell cycle D, where D is the latched dwell.
- At the edge ending dwell cycle D:
  - if another sweep step remains, {b,a} moves to the next enabled k above the current one, wrapping 3 to 0, and counter restarts at 1;
  - the step from the highest enabled k is the end of a sweep.
- End of sweep with continuous=1: wrap to the lowest enabled k and keep scanning.
- End of sweep with continuous=0: go to IDLE. busy=0 and done=1 for one cycle; a and b hold the last channel.
- Single enabled channel: {b,a} is constant. sample fires every D cycles in continuous mode, once in single mode.
- start while busy: ignored.
- Changes to chan_mask, dwell or continuous while busy: no effect until the next start.
- stop while busy:
  - at the next edge go to IDLE, busy=0, sample=0, done=0;
  - if sample was high in that same cycle, the strobe still counts (it was already presented).
- Back-to-back operation: start may be asserted in the same cycle done is high, because the block is already in IDLE. The new scan begins one edge later.
- Counter width is DWELL_W. The counter never exceeds D, so no overflow.
- Latency from start (sampled at edge N):
  - valid select after edge N+1;
  - first sample during the cycle after edge N+D;
  - single sweep with n enabled channels: done during the cycle after edge N+n*D+1.

Decomposition:
- Shared package mux_seq_pkg holds:
  - state constants ST_IDLE=2'd0 and ST_DWELL=2'd1;
  - SEL_W=2;
  - a function mapping select value to source number (k to 4-k).
- One combinational sub-module, next_chan_finder:
  - inputs: current k and the 4-bit mask;
  - outputs: the next enabled k (rotating priority above current, with wrap), the lowest enabled k, and a wrap flag marking end of sweep.

Test Plan:
1. Reset: assert rst 2 cycles with start=1 -> a=0, b=0, busy=0, sample=0, done=0 throughout.
2. mask=4'b1111, dwell=3, continuous=0, start -> {b,a} sequence 0,1,2,3, 3 cycles each. Four sample pulses, one on each third cycle. Single done pulse after the 12th dwell cycle, with busy falling at the same time.
3. mask=4'b1010, dwell=2, continuous=1 -> {b,a} alternates 1,3,1,3 with sample every 2nd cycle. stop in the 7th dwell cycle -> busy=0 at next edge, no done.
4. mask=4'b0110, dwell=0, continuous=0 -> {b,a}=1 for 1 cycle with sample, then {b,a}=2 for 1 cycle with sample, then done.
5. start with mask=0 -> busy stays 0. Then start with mask=4'b0001, dwell=4, and change mask to 4'b1111 mid-dwell -> only k=0 is scanned, one sample, done.
6. rst asserted mid-scan (mask=4'b1111, dwell=5, during k=2) -> next edge: a=b=0, busy=0, no done. A fresh start then begins at k=0.

Source files
------------

// File: rtl/mux_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_seq_pkg
//  Description : Shared types and constants for the mux select sequencer.
//                State encoding, select width and a helper mapping a select
//                value k = {b,a} to the mux source it routes (x4..x1).
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_seq_pkg;

    localparam int SEL_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DWELL = ST_DWELL
    } state_e;

    // Select value k routes source x(4-k): k=0 -> x4, k=3 -> x1.
    function automatic logic [2:0] sel_to_source(input logic [SEL_W-1:0] k);
        return 3'd4 - {1'b0, k};
    endfunction

endpackage : mux_seq_pkg
`default_nettype wire

// File: rtl/next_chan_finder.sv
`default_nettype none
// ============================================================================
//  Module      : next_chan_finder
//  Description : Combinational channel picker for the select sequencer.
//                Given the current select k and the enable mask, returns the
//                next enabled k above the current one (wrapping to the lowest
//                enabled k), the lowest enabled k, and a wrap flag that marks
//                the end of a sweep (no enabled channel above the current).
//  Ports       : i_cur    - current select value
//                i_mask   - channel enable mask, bit k enables select k
//                o_next   - next select value in round-robin order
//                o_lowest - lowest enabled select value (0 if mask empty)
//                o_wrap   - 1 when stepping from i_cur ends the sweep
//  Revision    : 1.0 - initial release
// ============================================================================
module next_chan_finder
    import mux_seq_pkg::*;
(
    input  logic [SEL_W-1:0] i_cur,
    input  logic [3:0]       i_mask,
    output logic [SEL_W-1:0] o_next,
    output logic [SEL_W-1:0] o_lowest,
    output logic             o_wrap
);

    logic [SEL_W-1:0] w_above;
    logic             w_found;

    // Scanning downward leaves the smallest matching index in the result.
    always_comb begin
        o_lowest = '0;
        w_above  = '0;
        w_found  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_lowest = SEL_W'(i);
                if (i > int'(i_cur)) begin
                    w_above = SEL_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Nothing enabled above the current channel: this step closes the sweep
    // and the round-robin successor is the lowest enabled channel.
    assign o_wrap = ~w_found;
    assign o_next = w_found ? w_above : o_lowest;

endmodule : next_chan_finder
`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_sequencer
//  Description : Round-robin select generator for a 4-input mux. Scans the
//                enabled channels, holds each for a programmable dwell time
//                and strobes 'sample' in the last dwell cycle of each
//                channel. Supports single-sweep and continuous modes.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                start      - begin a scan (honoured only when idle)
//                stop       - abort scan, idle at next edge
//                continuous - 1 = repeat sweeps, 0 = one sweep (latched)
//                chan_mask  - enabled select values (latched)
//                dwell      - cycles per channel, 0 behaves as 1 (latched)
//                a, b       - registered mux select {b,a}
//                sample     - strobe in the last dwell cycle of a channel
//                busy       - scanning
//                done       - one-cycle pulse after a single sweep ends
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL_W = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [3:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               sample,
    output logic               busy,
    output logic               done
);

    // ------------------------------------------------------------------
    // State and configuration registers
    // ------------------------------------------------------------------
    state_e             r_state,  w_state_nx;
    logic [SEL_W-1:0]   r_sel,    w_sel_nx;
    logic [DWELL_W-1:0] r_cnt,    w_cnt_nx;
    logic [DWELL_W-1:0] r_dwell,  w_dwell_nx;
    logic [3:0]         r_mask,   w_mask_nx;
    logic               r_cont,   w_cont_nx;
    logic               r_done,   w_done_nx;
    // Armed: start has been accepted and configuration latched; the first
    // channel is driven on the following edge. Lives inside IDLE, so busy
    // stays low for this one cycle.
    logic               r_arm,    w_arm_nx;

    logic [SEL_W-1:0]   w_next;
    logic [SEL_W-1:0]   w_lowest;
    logic               w_wrap;
    logic               w_last;
    logic [DWELL_W-1:0] w_dwell_eff;

    next_chan_finder u_finder (
        .i_cur    (r_sel),
        .i_mask   (r_mask),
        .o_next   (w_next),
        .o_lowest (w_lowest),
        .o_wrap   (w_wrap)
    );

    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Counter runs 1..D, so equality with the latched dwell marks cycle D.
    assign w_last = (r_cnt == r_dwell);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_mask  <= '0;
            r_cont  <= 1'b0;
            r_done  <= 1'b0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_cnt   <= w_cnt_nx;
            r_dwell <= w_dwell_nx;
            r_mask  <= w_mask_nx;
            r_cont  <= w_cont_nx;
            r_done  <= w_done_nx;
            r_arm   <= w_arm_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_cnt_nx   = r_cnt;
        w_dwell_nx = r_dwell;
        w_mask_nx  = r_mask;
        w_cont_nx  = r_cont;
        w_done_nx  = 1'b0;
        w_arm_nx   = r_arm;

        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    // Stop beats start and cancels a pending arm.
                    w_arm_nx = 1'b0;
                end else if (r_arm) begin
                    w_arm_nx   = 1'b0;
                    w_state_nx = S_DWELL;
                    w_sel_nx   = w_lowest;
                    w_cnt_nx   = DWELL_W'(1);
                end else if (start && (chan_mask != 4'b0000)) begin
                    w_arm_nx   = 1'b1;
                    w_mask_nx  = chan_mask;
                    w_dwell_nx = w_dwell_eff;
                    w_cont_nx  = continuous;
                end
            end

            S_DWELL: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else if (w_last) begin
                    if (w_wrap && !r_cont) begin
                        // Single sweep finished; select holds last channel.
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                        w_done_nx  = 1'b1;
                    end else begin
                        // On wrap the finder already returns the lowest k.
                        w_sel_nx = w_next;
                        w_cnt_nx = DWELL_W'(1);
                    end
                end else begin
                    w_cnt_nx = r_cnt + DWELL_W'(1);
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_arm_nx   = 1'b0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a      = r_sel[0];
    assign b      = r_sel[1];
    assign busy   = (r_state == S_DWELL);
    assign sample = busy && w_last;
    assign done   = r_done;

endmodule : mux_sel_sequencer
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_sequencer
//  Description : Directed self-checking bench for mux_sel_sequencer.
//                Observed vector per check is {b, a, busy, sample, done}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_sequencer;

    localparam int DWELL_W = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [3:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               a;
    logic               b;
    logic               sample;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    mux_sel_sequencer #(.DWELL_W(DWELL_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .a          (a),
        .b          (b),
        .sample     (sample),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {b,a,busy,sample,done}=%b required %b", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] vec(input int sel, input bit bsy, input bit smp, input bit dn);
        logic [1:0] s;
        s = sel[1:0];
        return {s, bsy, smp, dn};
    endfunction

    function automatic logic [4:0] obs();
        return {b, a, busy, sample, done};
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        stop       = 1'b0;
        continuous = 1'b0;
        chan_mask  = 4'b1111;
        dwell      = 8'd3;

        // 1. Reset held two cycles with start asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("reset_c%0d", i), obs(), vec(0, 0, 0, 0));
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("reset_after", obs(), vec(0, 0, 0, 0));

        // 2. Full mask, dwell 3, single sweep.
        chan_mask = 4'b1111; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("t2_arm", obs(), vec(0, 0, 0, 0));
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("t2_c%0d", c), obs(), vec((c - 1) / 3, 1, (c % 3) == 0, 0));
        end
        step();
        check("t2_done", obs(), vec(3, 0, 0, 1));
        step();
        check("t2_idle", obs(), vec(3, 0, 0, 0));

        // 3. Mask 1010, dwell 2, continuous, stop in dwell cycle 7.
        chan_mask = 4'b1010; dwell = 8'd2; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            check($sformatf("t3_c%0d", c), obs(),
                  vec((((c - 1) / 2) % 2) == 1 ? 3 : 1, 1, (c % 2) == 0, 0));
            if (c == 4) begin
                // Start while busy must be ignored.
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_stop", obs(), vec(3, 0, 0, 0));
        step();
        check("t3_after", obs(), vec(3, 0, 0, 0));

        // 4. Mask 0110, dwell 0 treated as 1, single sweep.
        chan_mask = 4'b0110; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_arm", obs(), vec(3, 0, 0, 0));
        step();
        check("t4_k1", obs(), vec(1, 1, 1, 0));
        step();
        check("t4_k2", obs(), vec(2, 1, 1, 0));
        step();
        check("t4_done", obs(), vec(2, 0, 0, 1));
        step();
        check("t4_idle", obs(), vec(2, 0, 0, 0));

        // 5a. Start with empty mask is ignored.
        chan_mask = 4'b0000; dwell = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_empty%0d", i), obs(), vec(2, 0, 0, 0));
        end

        // 5b. Single channel, config changed mid-dwell.
        chan_mask = 4'b0001; dwell = 8'd4; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("t5_c%0d", c), obs(), vec(0, 1, c == 4, 0));
            if (c == 2) begin
                chan_mask  = 4'b1111;
                dwell      = 8'd1;
                continuous = 1'b1;
            end
        end
        step();
        check("t5_done", obs(), vec(0, 0, 0, 1));

        // 6. Reset mid-scan during k=2, then a fresh start.
        chan_mask = 4'b1111; dwell = 8'd5; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
        end
        check("t6_k2", obs(), vec(2, 1, 0, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst", obs(), vec(0, 0, 0, 0));
        step();
        check("t6_nodone", obs(), vec(0, 0, 0, 0));
        dwell = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t6_restart", obs(), vec(0, 1, 0, 0));
        step();
        check("t6_restart_smp", obs(), vec(0, 1, 1, 0));
        step();
        check("t6_restart_k1", obs(), vec(1, 1, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_sel_sequencer
`default_nettype wire
